ballot_controller: RTL and testbench

//  Parametrised successor to the 4-candidate voting machine: NUM_CAND debounced

---
 rtl/ballot_controller.sv | 188 ++++++++++++++++++
 tb/tb_ballot_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_controller.sv
// Ballot controller: debounced candidate buttons, one-vote-per-ballot FSM, saturating tallies, LED read-out.
// Optional macro WINNER_DETECT_EN adds registered leader/tie outputs.
module ballot_controller #(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 10,
    parameter int LED_HOLD_CYC = 16,
    parameter int LED_W        = 8,
    localparam int SEL_W       = $clog2(NUM_CAND),
    localparam int TOT_W       = CNT_W + SEL_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                ballot_en,
    input  logic                clear_all,
    input  logic [NUM_CAND-1:0] button,
    input  logic [SEL_W-1:0]    result_sel,
    output logic [LED_W-1:0]    led,
    output logic                ready,
    output logic                vote_strobe,
    output logic [SEL_W-1:0]    vote_cand,
    output logic                reject,
    output logic                saturated,
    output logic [TOT_W-1:0]    total_votes
`ifdef WINNER_DETECT_EN
    ,
    output logic [SEL_W-1:0]    leader,
    output logic                tie
`endif
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LED_HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, CONFIRM} state_t;

    state_t              state;
    logic [DB_W-1:0]     deb_cnt [NUM_CAND];
    logic [NUM_CAND-1:0] qual;
    logic [CNT_W-1:0]    cnt [NUM_CAND];
    logic [HOLD_W-1:0]   hold_cnt;

    logic                qual_any;
    logic                qual_multi;
    logic [SEL_W-1:0]    qual_idx;
    logic [CNT_W+LED_W-1:0] sel_ext;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) deb_cnt[i] <= '0;
            qual <= '0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (!button[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DB_W'(DEBOUNCE_CYC))
                    deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
                qual[i] <= button[i] && (deb_cnt[i] == DB_W'(DEBOUNCE_CYC - 1));
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        qual_any   = 1'b0;
        qual_multi = 1'b0;
        qual_idx   = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (qual[i]) begin
                if (qual_any) qual_multi = 1'b1;
                qual_any = 1'b1;
                qual_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ext = '0;
        if (int'(result_sel) < NUM_CAND)
            sel_ext = {{LED_W{1'b0}}, cnt[result_sel]};
    end

    // NOTE: the tally array is reset deliberately; the vote counts must be zero after power-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
            hold_cnt    <= '0;
            led         <= '0;
            ready       <= 1'b0;
            vote_strobe <= 1'b0;
            vote_cand   <= '0;
            reject      <= 1'b0;
            saturated   <= 1'b0;
            total_votes <= '0;
        end else begin
            vote_strobe <= 1'b0;
            reject      <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (mode) begin
                        led <= sel_ext[LED_W-1:0];
                        if (clear_all) begin
                            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
                            total_votes <= '0;
                            saturated   <= 1'b0;
                        end
                    end else begin
                        led <= '0;
                        if (ballot_en) begin
                            state <= ARMED;
                            ready <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    led <= '0;
                    // A mode change wins over a simultaneous qualified press.
                    if (mode) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end else if (qual_multi) begin
                        reject <= 1'b1;
                    end else if (qual_any) begin
                        if (cnt[qual_idx] != CNT_MAX)
                            cnt[qual_idx] <= cnt[qual_idx] + CNT_W'(1);
                        if (cnt[qual_idx] >= CNT_MAX - CNT_W'(1))
                            saturated <= 1'b1;
                        if (total_votes != TOT_MAX)
                            total_votes <= total_votes + TOT_W'(1);
                        vote_strobe <= 1'b1;
                        vote_cand   <= qual_idx;
                        ready       <= 1'b0;
                        led         <= '1;
                        hold_cnt    <= '0;
                        state       <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (hold_cnt == HOLD_W'(LED_HOLD_CYC - 1)) begin
                        led   <= '0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WINNER_DETECT_EN
    logic [CNT_W-1:0] best;
    logic [SEL_W-1:0] lead_c;
    int               n_max;

    // Lowest index wins among equal maxima; all-zero tallies count as a tie.
    always_comb begin
        best   = '0;
        lead_c = '0;
        n_max  = 0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt[i] > best) begin
                best   = cnt[i];
                lead_c = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++)
            if (cnt[i] == best) n_max++;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leader <= '0;
            tie    <= 1'b0;
        end else begin
            leader <= lead_c;
            tie    <= (n_max > 1);
        end
    end
`endif

endmodule

// File: tb/tb_ballot_controller.sv
// Scoreboard bench for ballot_controller: stimulus queues expected strobe/reject events, a monitor pops them.
module tb_ballot_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic       ballot_en;
    logic       clear_all;
    logic [3:0] button;
    logic [1:0] result_sel;

    logic [7:0] led;
    logic       ready;
    logic       vote_strobe;
    logic [1:0] vote_cand;
    logic       reject;
    logic       saturated;
    logic [9:0] total_votes;

    logic [7:0] s_led;
    logic       s_ready;
    logic       s_strobe;
    logic [1:0] s_cand;
    logic       s_reject;
    logic       s_saturated;
    logic [3:0] s_total;

    always #5 clock = ~clock;

    ballot_controller dut (
        .clock(clock), .reset(reset), .mode(mode), .ballot_en(ballot_en),
        .clear_all(clear_all), .button(button), .result_sel(result_sel),
        .led(led), .ready(ready), .vote_strobe(vote_strobe), .vote_cand(vote_cand),
        .reject(reject), .saturated(saturated), .total_votes(total_votes)
    );

    // Narrow-counter copy sharing all inputs, used for the saturation case.
    ballot_controller #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .mode(mode), .ballot_en(ballot_en),
        .clear_all(clear_all), .button(button), .result_sel(result_sel),
        .led(s_led), .ready(s_ready), .vote_strobe(s_strobe), .vote_cand(s_cand),
        .reject(s_reject), .saturated(s_saturated), .total_votes(s_total)
    );

    typedef enum {EV_VOTE, EV_REJECT} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [1:0] cand;
        logic [9:0] total;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  exp_cnt [4];
    int  exp_total;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_vote(input int c);
        ev_t e;
        exp_cnt[c]++;
        exp_total++;
        e.kind  = EV_VOTE;
        e.cand  = 2'(c);
        e.total = 10'(exp_total);
        exp_q.push_back(e);
    endtask

    task automatic exp_reject();
        ev_t e;
        e.kind  = EV_REJECT;
        e.cand  = '0;
        e.total = '0;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] m, input int n);
        @(negedge clock);
        button = m;
        repeat (n) @(negedge clock);
        button = '0;
    endtask

    task automatic arm();
        @(negedge clock);
        mode      = 1'b0;
        ballot_en = 1'b1;
        @(negedge clock);
        ballot_en = 1'b0;
        check("ready_after_arm", ready, 1);
    endtask

    always @(negedge clock) begin
        if (reset && (vote_strobe || reject)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: strobe=%0b reject=%0b cand=%0d, expected none",
                         vote_strobe, reject, vote_cand);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.kind == EV_VOTE) begin
                    check("mon_strobe", vote_strobe, 1);
                    check("mon_cand", vote_cand, mon_ev.cand);
                    check("mon_total", total_votes, mon_ev.total);
                end else begin
                    check("mon_reject", reject, 1);
                    check("mon_reject_no_strobe", vote_strobe, 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        reset = 1'b0; mode = 1'b0; ballot_en = 1'b0; clear_all = 1'b0;
        button = '0; result_sel = '0;
        exp_total = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        repeat (3) @(negedge clock);
        check("rst_led", led, 0);
        check("rst_ready", ready, 0);
        check("rst_strobe", vote_strobe, 0);
        check("rst_reject", reject, 0);
        check("rst_saturated", saturated, 0);
        check("rst_total", total_votes, 0);
        reset = 1'b1;

        // Single vote for candidate 2 and LED hold length.
        arm();
        exp_vote(2);
        press(4'b0100, 10);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (led == 8'hFF) hi++;
            else if (hi > 0) break;
        end
        check("led_hold_cycles", hi, 16);
        check("ready_after_confirm", ready, 0);

        // Short press is not a vote.
        arm();
        press(4'b0010, 9);
        repeat (5) @(negedge clock);
        check("short_press_ready", ready, 1);

        // Two buttons together are rejected, then a single press counts.
        exp_reject();
        press(4'b1001, 10);
        repeat (3) @(negedge clock);
        check("reject_stays_armed", ready, 1);
        exp_vote(3);
        press(4'b1000, 10);
        repeat (20) @(negedge clock);

        // One ballot, two presses: only the first counts; presses in IDLE ignored.
        arm();
        exp_vote(0);
        press(4'b0001, 10);
        press(4'b0010, 10);
        repeat (10) @(negedge clock);
        press(4'b0010, 10);
        repeat (5) @(negedge clock);
        check("idle_press_ready", ready, 0);

        // Four votes for candidate 1 saturate the 2-bit copy.
        for (int v = 0; v < 4; v++) begin
            arm();
            exp_vote(1);
            press(4'b0010, 10);
            repeat (20) @(negedge clock);
        end
        check("sat_main_flag", saturated, 0);
        check("sat_small_flag", s_saturated, 1);
        check("sat_small_total", s_total, 7);
        check("main_total", total_votes, exp_total);

        // Result read-out; ballot_en is ignored in mode 1.
        @(negedge clock);
        mode = 1'b1;
        ballot_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            result_sel = 2'(c);
            @(negedge clock);
            check("readout_main", led, exp_cnt[c]);
            check("readout_small", s_led, (exp_cnt[c] > 3) ? 3 : exp_cnt[c]);
        end
        check("mode1_no_arm", ready, 0);
        ballot_en = 1'b0;

        // Clear all tallies.
        result_sel = 2'd1;
        @(negedge clock);
        clear_all = 1'b1;
        @(negedge clock);
        clear_all = 1'b0;
        check("clear_total", total_votes, 0);
        check("clear_small_total", s_total, 0);
        check("clear_small_sat", s_saturated, 0);
        @(negedge clock);
        check("clear_led", led, 0);
        exp_total = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        // Reset asserted mid-CONFIRM.
        arm();
        exp_vote(2);
        press(4'b0100, 10);
        @(negedge clock);
        check("confirm_led_on", led, 8'hFF);
        #2 reset = 1'b0;
        #1;
        check("midreset_led", led, 0);
        check("midreset_ready", ready, 0);
        check("midreset_total", total_votes, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset_led", led, 0);
        check("post_reset_ready", ready, 0);
        arm();
        @(negedge clock);
        mode = 1'b1;
        @(negedge clock);
        check("mode_cancels_ballot", ready, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
